// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer
//   Known-answer-test controller for the AES datapath. One accepted start runs
//   a full round trip: wait for the cipher core, capture its output, feed it to
//   the decipher core, capture the result, score both against the expected
//   vectors, then scroll all 32 captured bytes to the display path.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start, mode     begin test (sampled only in IDLE); key size 00/01/10, 11 illegal
//   plaintext       test input and expected decipher result
//   exp_cipher      expected ciphertext for the selected mode
//   cipher_out      cipher core output
//   decipher_out    decipher core output
//   dec_en, dec_in  decipher core enable and registered ciphertext
//   busy, done      test in progress, one-cycle completion pulse
//   pass_enc/dec    ciphertext / plaintext matched; isEqual = both
//   mode_err        last start used mode 11
//   disp_byte/idx   byte on the display path and its scroll position 0..31
module aes_kat_sequencer #(
    parameter int ENC_LAT_128 = 11,
    parameter int ENC_LAT_192 = 13,
    parameter int ENC_LAT_256 = 15,
    parameter int DEC_LAT_128 = 11,
    parameter int DEC_LAT_192 = 13,
    parameter int DEC_LAT_256 = 15,
    parameter int DWELL       = 50000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [127:0] plaintext,
    input  logic [127:0] exp_cipher,
    input  logic [127:0] cipher_out,
    input  logic [127:0] decipher_out,
    output logic         dec_en,
    output logic [127:0] dec_in,
    output logic         busy,
    output logic         done,
    output logic         pass_enc,
    output logic         pass_dec,
    output logic         isEqual,
    output logic         mode_err,
    output logic [7:0]   disp_byte,
    output logic [4:0]   disp_idx
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LAT_MAX = max2(max2(max2(ENC_LAT_128, ENC_LAT_192), max2(ENC_LAT_256, DEC_LAT_128)),
                                  max2(DEC_LAT_192, DEC_LAT_256));
    localparam int LAT_W   = $clog2(LAT_MAX) + 1;
    localparam int DWELL_W = $clog2(DWELL) + 1;
    // One shared counter serves both latency waits and the dwell timer.
    localparam int CNT_W   = max2(LAT_W, DWELL_W);

    localparam logic [CNT_W-1:0] ENC_T128 = CNT_W'(ENC_LAT_128 - 1);
    localparam logic [CNT_W-1:0] ENC_T192 = CNT_W'(ENC_LAT_192 - 1);
    localparam logic [CNT_W-1:0] ENC_T256 = CNT_W'(ENC_LAT_256 - 1);
    localparam logic [CNT_W-1:0] DEC_T128 = CNT_W'(DEC_LAT_128 - 1);
    localparam logic [CNT_W-1:0] DEC_T192 = CNT_W'(DEC_LAT_192 - 1);
    localparam logic [CNT_W-1:0] DEC_T256 = CNT_W'(DEC_LAT_256 - 1);
    localparam logic [CNT_W-1:0] DWELL_T  = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ENC, WAIT_DEC, SHOW} state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] enc_term, dec_term;
    logic [127:0]     pd_q;
    logic [127:0]     disp_src;
    logic             enc_last, dec_last, dwell_last, idx_last;

    always_comb begin
        case (mode_q)
            2'b00:   begin enc_term = ENC_T128; dec_term = DEC_T128; end
            2'b01:   begin enc_term = ENC_T192; dec_term = DEC_T192; end
            default: begin enc_term = ENC_T256; dec_term = DEC_T256; end
        endcase
    end

    assign enc_last   = (cnt == enc_term);
    assign dec_last   = (cnt == dec_term);
    assign dwell_last = (cnt == DWELL_T);
    assign idx_last   = (disp_idx == 5'd31);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start && mode != 2'b11) state_nxt = WAIT_ENC;
            WAIT_ENC: if (enc_last)               state_nxt = WAIT_DEC;
            WAIT_DEC: if (dec_last)               state_nxt = SHOW;
            SHOW:     if (dwell_last && idx_last) state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Registered outputs, captures and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= '0;
            cnt      <= '0;
            dec_en   <= 1'b0;
            dec_in   <= '0;
            pd_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_enc <= 1'b0;
            pass_dec <= 1'b0;
            isEqual  <= 1'b0;
            mode_err <= 1'b0;
            disp_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == 2'b11) begin
                            mode_err <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            mode_q   <= mode;
                            pass_enc <= 1'b0;
                            pass_dec <= 1'b0;
                            isEqual  <= 1'b0;
                            mode_err <= 1'b0;
                            cnt      <= '0;
                            busy     <= 1'b1;
                        end
                    end
                end
                WAIT_ENC: begin
                    if (enc_last) begin
                        dec_in   <= cipher_out;
                        pass_enc <= (cipher_out == exp_cipher);
                        cnt      <= '0;
                        dec_en   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DEC: begin
                    if (dec_last) begin
                        pd_q     <= decipher_out;
                        pass_dec <= (decipher_out == plaintext);
                        isEqual  <= pass_enc & (decipher_out == plaintext);
                        dec_en   <= 1'b0;
                        cnt      <= '0;
                        disp_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (dwell_last) begin
                        cnt <= '0;
                        if (idx_last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            disp_idx <= disp_idx + 5'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display byte: idx[4] picks ciphertext/plaintext, ~idx[3:0] turns the
    // MSB-first position into the byte offset from the LSB.
    always_comb begin
        disp_src  = disp_idx[4] ? pd_q : dec_in;
        disp_byte = disp_src[{~disp_idx[3:0], 3'b000} +: 8];
    end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
module tb_aes_kat_sequencer;

    localparam int DW = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [127:0] plaintext, exp_cipher, cipher_out, decipher_out;
    logic         dec_en, busy, done, pass_enc, pass_dec, isEqual, mode_err;
    logic [127:0] dec_in;
    logic [7:0]   disp_byte;
    logic [4:0]   disp_idx;

    aes_kat_sequencer #(.DWELL(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .plaintext(plaintext), .exp_cipher(exp_cipher),
        .cipher_out(cipher_out), .decipher_out(decipher_out),
        .dec_en(dec_en), .dec_in(dec_in), .busy(busy), .done(done),
        .pass_enc(pass_enc), .pass_dec(pass_dec), .isEqual(isEqual),
        .mode_err(mode_err), .disp_byte(disp_byte), .disp_idx(disp_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // cyc holds the number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cipher core stub: presents the ciphertext only in the single cycle
    // before the edge at which it must be sampled; junk otherwise.
    logic [127:0] stub_ct = '0;
    int           enc_valid_cyc = -100;
    always_comb cipher_out = (cyc == enc_valid_cyc) ? stub_ct : ~stub_ct;

    // Decipher core stub: result valid only once dec_en has been high for
    // the decipher latency.
    logic [127:0] stub_pt = '0;
    int           dec_lat_sel = 11;
    int           dcnt = 0;
    always @(posedge clk) dcnt <= dec_en ? dcnt + 1 : 0;
    always_comb decipher_out = (dec_en && dcnt == dec_lat_sel - 1) ? stub_pt : ~stub_pt;

    int enc_tab[3] = '{11, 13, 15};
    int dec_tab[3] = '{11, 13, 15};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [127:0] ct, input logic [127:0] pt, input int idx);
        logic [127:0] v;
        int pos;
        v   = (idx < 16) ? ct : pt;
        pos = idx % 16;
        return 8'((v >> (8 * (15 - pos))) & 128'hff);
    endfunction

    // Drives start at the current (falling) edge and follows the run until
    // the cycle in which done is due; returns at that falling edge.
    task automatic run_test(input logic [1:0] m, input logic [127:0] pt, input logic [127:0] expc,
                            input logic [127:0] sct, input logic [127:0] spt, input bit pester,
                            input logic epe, input logic epd, input logic eeq, input string tag);
        int el, dl, e0, s, endc, c, done_at, ndone, bad_busy, bad_den, bad_disp;
        logic exp_b, exp_d;
        el = enc_tab[m];
        dl = dec_tab[m];
        e0 = cyc + 1;
        s  = e0 + el + dl;
        endc = s + 32 * DW;
        stub_ct = sct;
        stub_pt = spt;
        enc_valid_cyc = cyc + el;
        dec_lat_sel = dl;
        plaintext = pt;
        exp_cipher = expc;
        mode = m;
        start = 1'b1;
        done_at = -1; ndone = 0; bad_busy = 0; bad_den = 0; bad_disp = 0;
        for (int k = 0; k <= endc - e0; k++) begin
            @(negedge clk);
            c = cyc;
            exp_b = (c >= e0 && c < endc);
            exp_d = (c >= e0 + el && c < s);
            if (busy !== exp_b) bad_busy++;
            if (dec_en !== exp_d) bad_den++;
            if (c >= s && c <= endc) begin
                int idx;
                idx = (c < endc) ? (c - s) / DW : 31;
                if (disp_byte !== model_byte(sct, spt, idx)) bad_disp++;
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            start = pester && (c < endc);
            mode  = pester ? 2'($urandom_range(0, 3)) : m;
        end
        chk({tag, "_done_lat"}, 128'(done_at - e0), 128'(endc - e0));
        chk({tag, "_done_cnt"}, 128'(ndone), 128'd1);
        chk({tag, "_busy_shape"}, 128'(bad_busy), 128'd0);
        chk({tag, "_dec_en_shape"}, 128'(bad_den), 128'd0);
        chk({tag, "_disp_seq"}, 128'(bad_disp), 128'd0);
        chk({tag, "_flags"}, {pass_enc, pass_dec, isEqual, mode_err}, {epe, epd, eeq, 1'b0});
        chk({tag, "_dec_in"}, dec_in, sct);
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic [127:0] pt, expc, sct, spt;
        logic         pe, pd, eq;
        logic [7:0]   last;
    } vec_t;

    localparam logic [127:0] P    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    vec_t vecs[5];

    initial begin
        logic [1:0]   rm;
        logic [127:0] rpt, rexp, rct, rdp;
        logic         mpe, mpd;

        vecs[0] = '{2'b00, P, C128, C128, P,                 1'b1, 1'b1, 1'b1, 8'hff};
        vecs[1] = '{2'b01, P, C192, C192, P,                 1'b1, 1'b1, 1'b1, 8'hff};
        vecs[2] = '{2'b10, P, C256, C256, P,                 1'b1, 1'b1, 1'b1, 8'hff};
        vecs[3] = '{2'b00, P, C128, C128, P ^ 128'd1,        1'b1, 1'b0, 1'b0, 8'hfe};
        vecs[4] = '{2'b10, P, C256, C256 ^ {1'b1, 127'd0}, P, 1'b0, 1'b1, 1'b0, 8'hff};

        reset = 1'b1; start = 1'b0; mode = 2'b00; plaintext = '0; exp_cipher = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, dec_en, pass_enc, pass_dec, isEqual, mode_err, disp_byte, disp_idx}, '0);
        chk("reset_dec_in", dec_in, '0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, back to back (each start lands in the done cycle)
        for (int i = 0; i < 5; i++) begin
            run_test(vecs[i].mode, vecs[i].pt, vecs[i].expc, vecs[i].sct, vecs[i].spt, 1'b0,
                     vecs[i].pe, vecs[i].pd, vecs[i].eq, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_last_byte", i), {120'd0, disp_byte}, {120'd0, vecs[i].last});
        end

        // Re-establish isEqual=1 so the illegal start can be seen to leave it alone
        run_test(2'b00, P, C128, C128, P, 1'b0, 1'b1, 1'b1, 1'b1, "pre_illegal");

        // Illegal mode
        mode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'b00;
        chk("illegal_pulse", {done, mode_err, busy, dec_en}, 4'b1100);
        @(negedge clk);
        chk("illegal_after", {done, mode_err, busy, dec_en, isEqual}, 5'b01001);
        repeat (3) @(negedge clk);
        chk("illegal_idle", {busy, dec_en, done}, 3'b000);

        // Start hammered throughout the run with random mode: must not restart
        run_test(2'b00, P, C128, C128, P, 1'b1, 1'b1, 1'b1, 1'b1, "pester");

        // Reset during WAIT_DEC
        stub_ct = C128; stub_pt = P; enc_valid_cyc = cyc + 11; dec_lat_sel = 11;
        plaintext = P; exp_cipher = C128; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_reset_state", {busy, dec_en, pass_enc}, 3'b111);
        #2 reset = 1'b1;
        #1;
        chk("reset_async_outs", {busy, done, dec_en, pass_enc, pass_dec, isEqual, mode_err, disp_byte, disp_idx}, '0);
        chk("reset_async_dec_in", dec_in, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_test(2'b00, P, C128, C128, P, 1'b0, 1'b1, 1'b1, 1'b1, "post_reset");

        // Randomized runs scored by the reference model
        for (int r = 0; r < 8; r++) begin
            rm   = 2'($urandom_range(0, 2));
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rexp = {$urandom, $urandom, $urandom, $urandom};
            rct  = ($urandom_range(0, 1) == 1) ? rexp : rexp ^ (128'd1 << $urandom_range(0, 127));
            rdp  = ($urandom_range(0, 1) == 1) ? rpt  : rpt  ^ (128'd1 << $urandom_range(0, 127));
            mpe  = (rct == rexp);
            mpd  = (rdp == rpt);
            run_test(rm, rpt, rexp, rct, rdp, 1'b0, mpe, mpd, mpe && mpd, $sformatf("rand%0d", r));
        end

        @(negedge clk);
        chk("final_idle", {busy, done, dec_en}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
